// File: rtl/i3c_cpuif_req_ctrl_if.sv
// i3c_cpuif_req_ctrl_if: front-end request/response and CSR cpuif signals of the request sequencer
interface i3c_cpuif_req_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_dv_i;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [2:0]            req_size_i;
  logic [31:0]           req_wdata_i;
  logic                  req_hld_o;
  logic                  resp_valid_o;
  logic                  resp_err_o;
  logic [31:0]           resp_rdata_o;
  logic                  s_cpuif_req_o;
  logic                  s_cpuif_req_is_wr_o;
  logic [ADDR_WIDTH-1:0] s_cpuif_addr_o;
  logic [31:0]           s_cpuif_wr_data_o;
  logic [31:0]           s_cpuif_wr_biten_o;
  logic                  s_cpuif_req_stall_wr_i;
  logic                  s_cpuif_req_stall_rd_i;
  logic                  s_cpuif_rd_ack_i;
  logic                  s_cpuif_rd_err_i;
  logic [31:0]           s_cpuif_rd_data_i;
  logic                  s_cpuif_wr_ack_i;
  logic                  s_cpuif_wr_err_i;
  modport slave (
    input  req_dv_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
    input  s_cpuif_req_stall_wr_i, s_cpuif_req_stall_rd_i,
    input  s_cpuif_rd_ack_i, s_cpuif_rd_err_i, s_cpuif_rd_data_i,
    input  s_cpuif_wr_ack_i, s_cpuif_wr_err_i,
    output req_hld_o, resp_valid_o, resp_err_o, resp_rdata_o,
    output s_cpuif_req_o, s_cpuif_req_is_wr_o, s_cpuif_addr_o,
    output s_cpuif_wr_data_o, s_cpuif_wr_biten_o
  );
  modport master (
    output req_dv_i, req_write_i, req_addr_i, req_size_i, req_wdata_i,
    output s_cpuif_req_stall_wr_i, s_cpuif_req_stall_rd_i,
    output s_cpuif_rd_ack_i, s_cpuif_rd_err_i, s_cpuif_rd_data_i,
    output s_cpuif_wr_ack_i, s_cpuif_wr_err_i,
    input  req_hld_o, resp_valid_o, resp_err_o, resp_rdata_o,
    input  s_cpuif_req_o, s_cpuif_req_is_wr_o, s_cpuif_addr_o,
    input  s_cpuif_wr_data_o, s_cpuif_wr_biten_o
  );
endinterface

// File: rtl/i3c_cpuif_req_ctrl.sv
// i3c_cpuif_req_ctrl: sequences one AHB client request onto the CSR cpuif with stall, ack and timeout handling
module i3c_cpuif_req_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int ACK_TIMEOUT = 255
) (
  input logic                   hclk_i,
  input logic                   hreset_n_i,
  i3c_cpuif_req_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                state_q, state_d;
  logic [15:0]           cnt_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, biten_q, rdata_q;
  logic                  err_q;
  logic                  legal, stall, ack, ack_err, done, timeout, err_d;
  logic [31:0]           biten, rdata_d;
  always_comb begin
    legal = bus.req_size_i == 3'd0 || (bus.req_size_i == 3'd1 && !bus.req_addr_i[0]) ||
            (bus.req_size_i == 3'd2 && bus.req_addr_i[1:0] == 2'b00);
    biten = !bus.req_write_i ? 32'h0 :
            bus.req_size_i == 3'd2 ? 32'hFFFF_FFFF :
            bus.req_size_i == 3'd1 ? 32'h0000_FFFF << {bus.req_addr_i[1], 4'b0} :
                                     32'h0000_00FF << {bus.req_addr_i[1:0], 3'b0};
    stall   = wr_q ? bus.s_cpuif_req_stall_wr_i : bus.s_cpuif_req_stall_rd_i;
    ack     = wr_q ? bus.s_cpuif_wr_ack_i : bus.s_cpuif_rd_ack_i;
    ack_err = wr_q ? bus.s_cpuif_wr_err_i : bus.s_cpuif_rd_err_i;
    done    = ack && (state_q == WAIT || (state_q == ISSUE && !stall));
    timeout = cnt_q == 16'(ACK_TIMEOUT);
    // a matching ack in the timeout cycle takes priority over the forced error
    state_d = state_q == IDLE ? (bus.req_dv_i ? (legal ? ISSUE : RESP) : IDLE) :
              state_q == RESP ? IDLE :
              (done || timeout) ? RESP :
              (state_q == ISSUE && stall) ? ISSUE : WAIT;
    err_d   = done ? ack_err : 1'b1;
    rdata_d = (done && !wr_q) ? bus.s_cpuif_rd_data_i : 32'h0;
  end
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      biten_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_dv_i) begin
        wr_q    <= bus.req_write_i;
        addr_q  <= {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
        wdata_q <= bus.req_wdata_i;
        biten_q <= biten;
        cnt_q   <= '0;
      end else if (state_q == ISSUE || state_q == WAIT) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (state_d == RESP && state_q != RESP) begin
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end
  end
  assign bus.req_hld_o           = (state_q == IDLE && bus.req_dv_i) || state_q == ISSUE || state_q == WAIT;
  assign bus.resp_valid_o        = state_q == RESP;
  assign bus.resp_err_o          = err_q;
  assign bus.resp_rdata_o        = rdata_q;
  assign bus.s_cpuif_req_o       = state_q == ISSUE;
  assign bus.s_cpuif_req_is_wr_o = wr_q;
  assign bus.s_cpuif_addr_o      = addr_q;
  assign bus.s_cpuif_wr_data_o   = wdata_q;
  assign bus.s_cpuif_wr_biten_o  = biten_q;
endmodule

// File: doc/i3c_cpuif_req_ctrl.md
# i3c_cpuif_req_ctrl

Request sequencer between the AHB-Lite subordinate front-end and the I3C CSR block's CPU interface. It captures one single-cycle client request, converts AHB size/address into a word address plus bit-level write enables, and drives the CSR `s_cpuif_*` request. It honours the read and write stall inputs, waits for the matching acknowledge, and returns read data and error status to the front-end with a hold/response handshake. An ack timeout guarantees the bus never hangs.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: CSR byte-address width.
- `ACK_TIMEOUT`, default 255: cycles from request issue to forced error. Legal range is 2..65535.

Ports (one clock; reset is asynchronous and active-low):
- `hclk_i` input, 1 bit: clock.
- `hreset_n_i` input, 1 bit: asynchronous active-low reset.
- `req_dv_i` input, 1 bit: single-cycle request pulse from the front-end.
- `req_write_i` input, 1 bit: 1 = write, 0 = read.
- `req_addr_i` input, ADDR_WIDTH bits: byte address.
- `req_size_i` input, 3 bits: AHB HSIZE encoding.
- `req_wdata_i` input, 32 bits: write data, already lane-aligned.
- `req_hld_o` output, 1 bit: transfer in progress; the front-end extends the data phase while this is high.
- `resp_valid_o` output, 1 bit: one-cycle completion pulse.
- `resp_err_o` output, 1 bit: error flag, valid with `resp_valid_o`.
- `resp_rdata_o` output, 32 bits: read data, valid with `resp_valid_o`.
- `s_cpuif_req_o` output, 1 bit: CSR request.
- `s_cpuif_req_is_wr_o` output, 1 bit: CSR request is a write.
- `s_cpuif_addr_o` output, ADDR_WIDTH bits: word-aligned CSR address.
- `s_cpuif_wr_data_o` output, 32 bits: CSR write data.
- `s_cpuif_wr_biten_o` output, 32 bits: CSR bit-level write enables.
- `s_cpuif_req_stall_wr_i` input, 1 bit: stalls write requests.
- `s_cpuif_req_stall_rd_i` input, 1 bit: stalls read requests.
- `s_cpuif_rd_ack_i` input, 1 bit: read acknowledge.
- `s_cpuif_rd_err_i` input, 1 bit: read error.
- `s_cpuif_rd_data_i` input, 32 bits: read data.
- `s_cpuif_wr_ack_i` input, 1 bit: write acknowledge.
- `s_cpuif_wr_err_i` input, 1 bit: write error.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - On `req_dv_i`, capture write, address, size and wdata.
  - Legal request: go to ISSUE.
  - Illegal request: go to RESP with err=1; no CSR request is issued.
  - `req_dv_i` outside IDLE is a protocol violation; it is ignored and the captured request is not disturbed.
- **Legality**
  - size 0: any address.
  - size 1: requires addr[0]=0.
  - size 2: requires addr[1:0]=0.
  - size ≥3: illegal.
- **Bit enables**
  - size 0: 0xFF << (8·addr[1:0]).
  - size 1: 0xFFFF << (16·addr[1]).
  - size 2: 0xFFFF_FFFF.
  - Reads drive biten = 0.
- **Address and data:** `s_cpuif_addr_o` is the captured address with [1:0] forced to 0. Write data is passed through unmodified.
- **ISSUE**
  - `s_cpuif_req_o`=1, driven by the state register.
  - The request is accepted in a cycle where the stall input for its direction is low.
  - Accepted with the matching ack in the same cycle: go to RESP.
  - Accepted without ack: go to WAIT.
  - Stalled: stay in ISSUE with request fields stable.
- **WAIT:** `s_cpuif_req_o`=0. On the matching ack, go to RESP.
  - The matching ack is `rd_ack` for reads and `wr_ack` for writes.
  - A non-matching ack is ignored.
- **Capture on ack**
  - Error source: `rd_err` for reads, `wr_err` for writes.
  - Read data: `rd_data` on reads; 0 on writes.
- **Timeout**
  - A 16-bit counter clears on entry to ISSUE and increments in each ISSUE/WAIT cycle; stall cycles count.
  - When the count reaches ACK_TIMEOUT with no matching ack: go to RESP with err=1, rdata=0. `s_cpuif_req_o` drops.
  - If the matching ack arrives in the same cycle the count reaches ACK_TIMEOUT, the ack wins.
- **RESP:** `resp_valid_o`=1 and `req_hld_o`=0 for exactly one cycle, then return to IDLE.
- **Stray acks:** acks arriving in IDLE or RESP (for example, late after a timeout) are dropped.

## Timing
- **Reset values:** all outputs are 0; state is IDLE; the counter is 0.
- **Reset mid-transfer:** asynchronous return to IDLE. `s_cpuif_req_o` and `req_hld_o` deassert immediately, with no response pulse.
- **`req_hld_o`:** combinationally high in the `req_dv_i` cycle while in IDLE (also for illegal requests), then registered high through ISSUE and WAIT. It is low in RESP.
- **Best-case latency:** dv at cycle 0, `s_cpuif_req_o` at cycle 1, same-cycle ack, `resp_valid_o` at cycle 2.
- **Each additional cycle adds one:** a stall cycle, or an ack cycle spent in WAIT.
- **Illegal request:** dv at cycle 0, `resp_valid_o` with err at cycle 1.
- **Timeout:** `resp_valid_o` arrives ACK_TIMEOUT+2 cycles after dv.
- **Registered outputs:** `resp_*` and `s_cpuif_*` are driven from flops; there is no combinational path from any input to any output other than `req_hld_o`.
- **Back-to-back:** a new dv is accepted in the cycle after RESP.

## Test plan
- Word write, size 2, addr 0x104, wdata 0xDEADBEEF, wr_ack on the first req cycle:
  - addr=0x104, biten=0xFFFFFFFF.
  - `resp_valid_o` at cycle 2 with err=0.
  - hld is high for cycles 0–1.
- Byte write, size 0, addr 0x0A3: biten=0xFF000000, addr=0x0A0. Halfword write at 0x0A2: biten=0xFFFF0000.
- Read at 0x010 with stall_rd high for 3 cycles, then a 2-cycle ack delay and rd_data=0x12345678:
  - req held 4 cycles with stable fields.
  - resp_rdata=0x12345678 at cycle 7.
  - stall_wr toggling during the read has no effect.
- Illegal requests, each giving `resp_valid_o` err=1 at cycle 1 with `s_cpuif_req_o` never asserted:
  - halfword at addr 0x001.
  - size 3 at addr 0x000.
- Timeout with ACK_TIMEOUT=8 and no ack:
  - err=1, rdata=0 at cycle 10.
  - A wr_ack injected in the following IDLE cycle is ignored.
  - The next read then completes normally.
- Reset asserted during WAIT: req/hld are 0 immediately, no `resp_valid_o`. After reset release a fresh write completes in 2 cycles.
